sram_arb_controller: RTL and testbench

SRAM_ARB_CONTROLLER -- requirements
Module: sram_arb_controller

---
 rtl/sram_arb_pkg.sv | 12 +
 rtl/rr_arbiter.sv | 34 +++
 rtl/sram_arb_controller.sv | 134 +++++++++++++
 tb/tb_sram_arb_controller.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/sram_arb_pkg.sv
// Shared constants for the SRAM arbiter/controller.
// Read latency is 2 cycles by default, 3 when SRAM_ARB_OUT_REG_EN is defined.
package sram_arb_pkg;
  localparam int MAX_PORTS   = 8;
  localparam int RD_LAT_BASE = 2;
  localparam int RD_LAT_REG  = 3;

  // Width of a port index; never narrower than one bit so single-port builds stay legal.
  function automatic int idx_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: grants the first requester at or after ptr,
// wrapping modulo N. Emits a one-hot grant, the winner index and an any-grant flag.
module rr_arbiter
  import sram_arb_pkg::*;
#(
  parameter int N  = 2,
  parameter int IW = idx_w(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] win,
  output logic          any
);

  // Scan N slots starting at ptr; the first requester found wins.
  always_comb begin
    int j;
    j   = 0;
    gnt = '0;
    win = '0;
    any = 1'b0;
    for (int k = 0; k < N; k++) begin
      j = int'(ptr) + k;
      if (j >= N) j = j - N;
      if (!any && req[j]) begin
        gnt[j] = 1'b1;
        win    = IW'(j);
        any    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sram_arb_controller.sv
// Multi-port SRAM controller: round-robin arbitration, registered SRAM command,
// read-tag pipeline routing read data back to the issuing port.
// Define SRAM_ARB_OUT_REG_EN to register rsp_valid/rsp_data (read latency 3 instead of 2).
module sram_arb_controller
  import sram_arb_pkg::*;
#(
  parameter int ADDR_WIDTH = 7,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_PORTS  = 2
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic [NUM_PORTS-1:0]            req_valid,
  output logic [NUM_PORTS-1:0]            req_ready,
  input  logic [NUM_PORTS-1:0]            req_rw,
  input  logic [NUM_PORTS*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0] req_write_data,
  output logic [NUM_PORTS-1:0]            rsp_valid,
  output logic [DATA_WIDTH-1:0]           rsp_data,
  input  logic [DATA_WIDTH-1:0]           sram_out_data,
  output logic                            sram_enable,
  output logic                            sram_rw,
  output logic [ADDR_WIDTH-1:0]           sram_addr,
  output logic [DATA_WIDTH-1:0]           sram_write_data
);

  localparam int IW = idx_w(NUM_PORTS);

  logic [NUM_PORTS-1:0]  gnt;
  logic [IW-1:0]         win;
  logic                  any;
  logic                  xfer;

  logic [IW-1:0]         rr_ptr_q, rr_ptr_d;
  logic                  sram_en_q, sram_en_d;
  logic                  sram_rw_q, sram_rw_d;
  logic [ADDR_WIDTH-1:0] sram_addr_q, sram_addr_d;
  logic [DATA_WIDTH-1:0] sram_wdata_q, sram_wdata_d;
  // Stage 0 lines up with the SRAM command, stage 1 with sram_out_data.
  logic [1:0]            vld_pipe_q, vld_pipe_d;
  logic [1:0][IW-1:0]    tag_pipe_q, tag_pipe_d;
  logic [NUM_PORTS-1:0]  rsp_vec;

  rr_arbiter #(.N(NUM_PORTS), .IW(IW)) u_arb (
    .req (req_valid),
    .ptr (rr_ptr_q),
    .gnt (gnt),
    .win (win),
    .any (any)
  );

  // Grants are suppressed during reset so nothing transfers on a reset edge.
  assign req_ready = reset ? '0 : gnt;
  assign xfer      = any & ~reset;

  // Next-state for pointer, SRAM command register and read-tag shift register.
  always_comb begin
    rr_ptr_d     = rr_ptr_q;
    sram_en_d    = xfer;
    sram_rw_d    = sram_rw_q;
    sram_addr_d  = sram_addr_q;
    sram_wdata_d = sram_wdata_q;
    if (xfer) begin
      rr_ptr_d     = (win == IW'(NUM_PORTS - 1)) ? '0 : win + IW'(1);
      sram_rw_d    = req_rw[win];
      sram_addr_d  = req_addr[int'(win)*ADDR_WIDTH +: ADDR_WIDTH];
      sram_wdata_d = req_write_data[int'(win)*DATA_WIDTH +: DATA_WIDTH];
    end
    vld_pipe_d    = {vld_pipe_q[0], xfer & ~req_rw[win]};
    tag_pipe_d[1] = tag_pipe_q[0];
    tag_pipe_d[0] = win;
  end

  // Controller state; reset also drops any reads still in flight.
  always_ff @(posedge clock) begin
    if (reset) begin
      rr_ptr_q     <= '0;
      sram_en_q    <= 1'b0;
      sram_rw_q    <= 1'b0;
      sram_addr_q  <= '0;
      sram_wdata_q <= '0;
      vld_pipe_q   <= '0;
      tag_pipe_q   <= '0;
    end else begin
      rr_ptr_q     <= rr_ptr_d;
      sram_en_q    <= sram_en_d;
      sram_rw_q    <= sram_rw_d;
      sram_addr_q  <= sram_addr_d;
      sram_wdata_q <= sram_wdata_d;
      vld_pipe_q   <= vld_pipe_d;
      tag_pipe_q   <= tag_pipe_d;
    end
  end

  assign sram_enable     = sram_en_q;
  assign sram_rw         = sram_rw_q;
  assign sram_addr       = sram_addr_q;
  assign sram_write_data = sram_wdata_q;

  // Decode the tag that is aligned with valid SRAM read data into a one-hot strobe.
  always_comb begin
    rsp_vec = '0;
    if (vld_pipe_q[1]) rsp_vec[tag_pipe_q[1]] = 1'b1;
  end

`ifdef SRAM_ARB_OUT_REG_EN
  logic [NUM_PORTS-1:0]  rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0] rsp_data_q, rsp_data_d;

  // Capture read data only when a response is due; otherwise hold it steady.
  always_comb begin
    rsp_valid_d = rsp_vec;
    rsp_data_d  = vld_pipe_q[1] ? sram_out_data : rsp_data_q;
  end

  // Output register stage for the response.
  always_ff @(posedge clock) begin
    if (reset) begin
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
    end else begin
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
`else
  assign rsp_valid = rsp_vec;
  assign rsp_data  = sram_out_data;
`endif

endmodule

// File: tb/tb_sram_arb_controller.sv
// Directed bench for sram_arb_controller: a 2-port instance driven from a vector
// table against a small SRAM model, plus a 4-port instance for pointer wrap checks.
module tb_sram_arb_controller;

`ifdef SRAM_ARB_OUT_REG_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 2;
`endif
  // After edge j, the visible response belongs to the transfer at edge j-D.
  localparam int D = LAT - 1;

  logic        clock = 1'b0;
  logic        reset;
  logic [1:0]  req_valid, req_ready, req_rw, rsp_valid;
  logic [13:0] req_addr;
  logic [63:0] req_write_data;
  logic [31:0] rsp_data, sram_out_data, sram_write_data;
  logic        sram_enable, sram_rw;
  logic [6:0]  sram_addr;

  logic [3:0]   v4, rdy4, rsp_v4;
  logic [31:0]  rsp_d4, sw4;
  logic         se4, srw4;
  logic [6:0]   sa4;

  logic [31:0] mem [128];

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  sram_arb_controller dut (
    .clock(clock), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_rw(req_rw), .req_addr(req_addr), .req_write_data(req_write_data),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .sram_out_data(sram_out_data),
    .sram_enable(sram_enable), .sram_rw(sram_rw), .sram_addr(sram_addr),
    .sram_write_data(sram_write_data)
  );

  sram_arb_controller #(.NUM_PORTS(4)) dut4 (
    .clock(clock), .reset(reset), .req_valid(v4), .req_ready(rdy4),
    .req_rw(4'b0), .req_addr(28'h0), .req_write_data(128'h0),
    .rsp_valid(rsp_v4), .rsp_data(rsp_d4), .sram_out_data(32'h0),
    .sram_enable(se4), .sram_rw(srw4), .sram_addr(sa4), .sram_write_data(sw4)
  );

  // Synchronous SRAM model: read data appears the cycle after the read is sampled.
  always @(posedge clock) begin
    if (sram_enable) begin
      if (sram_rw) mem[sram_addr] <= sram_write_data;
      else         sram_out_data  <= mem[sram_addr];
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [1:0]  v;
    logic [1:0]  rw;
    logic [6:0]  a0, a1;
    logic [31:0] wd0, wd1;
    logic [1:0]  exp_rdy;
    logic [1:0]  exp_rsp;
    logic [31:0] exp_dat;
  } vec_t;

  localparam int NV = 14;
  vec_t tbl [NV];

  function automatic vec_t mk(logic [1:0] v, logic [1:0] rw, logic [6:0] a0, logic [6:0] a1,
                              logic [31:0] wd0, logic [31:0] wd1, logic [1:0] rdy,
                              logic [1:0] rsp, logic [31:0] dat);
    vec_t t;
    t.v = v; t.rw = rw; t.a0 = a0; t.a1 = a1; t.wd0 = wd0; t.wd1 = wd1;
    t.exp_rdy = rdy; t.exp_rsp = rsp; t.exp_dat = dat;
    return t;
  endfunction

  initial begin
    logic [6:0]  last_addr;
    logic [31:0] last_wdata;
    logic [1:0]  er;
    logic [31:0] ed;
    for (int a = 0; a < 128; a++) mem[a] = {8{a[3:0]}};
    sram_out_data = '0;

    // rr_ptr starts at 0; comments give the pointer after each row.
    tbl[0]  = mk(2'b01, 2'b00, 7'd1, 7'd0, 0, 0,                     2'b01, 2'b01, 32'h11111111); // ptr1
    tbl[1]  = mk(2'b00, 2'b00, 7'd0, 7'd0, 0, 0,                     2'b00, 2'b00, 32'h0);
    tbl[2]  = mk(2'b01, 2'b00, 7'd2, 7'd0, 0, 0,                     2'b01, 2'b01, 32'h22222222); // ptr1
    tbl[3]  = mk(2'b10, 2'b00, 7'd0, 7'd5, 0, 0,                     2'b10, 2'b10, 32'h55555555); // ptr0
    tbl[4]  = mk(2'b11, 2'b00, 7'd6, 7'd7, 0, 0,                     2'b01, 2'b01, 32'h66666666); // ptr1
    tbl[5]  = mk(2'b11, 2'b00, 7'd6, 7'd7, 0, 0,                     2'b10, 2'b10, 32'h77777777); // ptr0
    tbl[6]  = mk(2'b11, 2'b00, 7'd6, 7'd7, 0, 0,                     2'b01, 2'b01, 32'h66666666); // ptr1
    tbl[7]  = mk(2'b11, 2'b00, 7'd6, 7'd7, 0, 0,                     2'b10, 2'b10, 32'h77777777); // ptr0
    tbl[8]  = mk(2'b10, 2'b10, 7'd0, 7'd3, 0, 32'h56789ABC,          2'b10, 2'b00, 32'h0);        // ptr0
    tbl[9]  = mk(2'b01, 2'b00, 7'd3, 7'd0, 0, 0,                     2'b01, 2'b01, 32'h56789ABC); // ptr1
    tbl[10] = mk(2'b01, 2'b01, 7'd4, 7'd0, 32'hDEADBEEF, 0,          2'b01, 2'b00, 32'h0);        // ptr1
    tbl[11] = mk(2'b11, 2'b11, 7'd9, 7'd8, 32'h0BADF00D, 32'hCAFEF00D, 2'b10, 2'b00, 32'h0);      // ptr0
    tbl[12] = mk(2'b01, 2'b00, 7'd4, 7'd0, 0, 0,                     2'b01, 2'b01, 32'hDEADBEEF); // ptr1
    tbl[13] = mk(2'b00, 2'b00, 7'd0, 7'd0, 0, 0,                     2'b00, 2'b00, 32'h0);

    // Reset with every port requesting: grants must stay low.
    reset = 1'b1; req_valid = 2'b11; req_rw = '0; req_addr = '0; req_write_data = '0;
    v4 = 4'b1111;
    repeat (2) @(posedge clock);
    @(negedge clock);
    check("rst_ready", req_ready, 2'b00);
    check("rst_ready4", rdy4, 4'b0000);
    check("rst_sram_en", sram_enable, 1'b0);
    check("rst_sram_rw", sram_rw, 1'b0);
    check("rst_sram_addr", sram_addr, 7'd0);
    check("rst_sram_wdata", sram_write_data, 32'h0);
    check("rst_rsp_valid", rsp_valid, 2'b00);
    reset = 1'b0; req_valid = 2'b00; v4 = 4'b0000;

    // Vector table.
    last_addr = '0; last_wdata = '0;
    for (int i = 0; i < NV + D; i++) begin
      @(negedge clock);
      if (i < NV) begin
        req_valid      = tbl[i].v;
        req_rw         = tbl[i].rw;
        req_addr       = {tbl[i].a1, tbl[i].a0};
        req_write_data = {tbl[i].wd1, tbl[i].wd0};
      end else begin
        req_valid = '0; req_rw = '0; req_addr = '0; req_write_data = '0;
      end
      #1;
      if (i < NV) check($sformatf("ready[%0d]", i), req_ready, tbl[i].exp_rdy);
      @(posedge clock); #1;
      if (i < NV && tbl[i].exp_rdy != 2'b00) begin
        last_addr  = tbl[i].exp_rdy[1] ? tbl[i].a1  : tbl[i].a0;
        last_wdata = tbl[i].exp_rdy[1] ? tbl[i].wd1 : tbl[i].wd0;
        check($sformatf("sram_en[%0d]", i), sram_enable, 1'b1);
        check($sformatf("sram_rw[%0d]", i), sram_rw,
              tbl[i].exp_rdy[1] ? tbl[i].rw[1] : tbl[i].rw[0]);
      end else begin
        check($sformatf("sram_en[%0d]", i), sram_enable, 1'b0);
      end
      check($sformatf("sram_addr[%0d]", i), sram_addr, last_addr);
      check($sformatf("sram_wdata[%0d]", i), sram_write_data, last_wdata);
      er = 2'b00; ed = '0;
      if (i >= D) begin er = tbl[i-D].exp_rsp; ed = tbl[i-D].exp_dat; end
      check($sformatf("rsp_valid[%0d]", i), rsp_valid, er);
      if (er != 2'b00) check($sformatf("rsp_data[%0d]", i), rsp_data, ed);
    end

    // Read in flight, then a one-cycle reset: the read must never return.
    @(negedge clock);
    req_valid = 2'b01; req_rw = 2'b00; req_addr = {7'd0, 7'd1};
    #1 check("inflight_ready", req_ready, 2'b01);
    @(negedge clock);
    reset = 1'b1; req_valid = 2'b11;
    #1 check("rst_hi_ready", req_ready, 2'b00);
    @(negedge clock);
    reset = 1'b0; req_valid = 2'b00;
    check("post_rst_en", sram_enable, 1'b0);
    check("post_rst_addr", sram_addr, 7'd0);
    check("post_rst_rsp", rsp_valid, 2'b00);
    for (int k = 0; k < 4; k++) begin
      @(posedge clock); #1;
      check($sformatf("drop_rsp[%0d]", k), rsp_valid, 2'b00);
      check($sformatf("drop_en[%0d]", k), sram_enable, 1'b0);
    end
    @(negedge clock);
    req_valid = 2'b11;
    #1 check("post_rst_ptr0", req_ready, 2'b01);
    @(negedge clock);
    req_valid = 2'b00;

    // Four ports: move pointer to 2, then ports 1 and 3 contend.
    @(negedge clock);
    v4 = 4'b0010;
    #1 check("p4_first", rdy4, 4'b0010);
    @(negedge clock);
    v4 = 4'b1010;
    #1 check("p4_ptr2_gnt3", rdy4, 4'b1000);
    @(negedge clock);
    #1 check("p4_wrap_gnt1", rdy4, 4'b0010);
    @(negedge clock);
    v4 = 4'b0000;
    #1 check("p4_idle", rdy4, 4'b0000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
